// File: rtl/nt_node_pipe_if.sv
// nt_node_pipe_if: groups the operand, control and result signals of the
// trust node. The master drives operands, pol, valid_in and cnt_clr; the slave drives the results.
interface nt_node_pipe_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             valid_in;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_c;
    logic [WIDTH-1:0] in_d;
    logic [WIDTH-1:0] in_e;
    logic [WIDTH-1:0] in_f;
    logic [WIDTH-1:0] in_g;
    logic             pol;
    logic             cnt_clr;
    logic [WIDTH-1:0] out_node;
    logic             out_valid;
    logic [CNT_W-1:0] rare_cnt;
    logic             rare_sat;

    modport master (
        output valid_in, in_a, in_b, in_c, in_d,
        output in_e, in_f, in_g, pol, cnt_clr,
        input  out_node, out_valid, rare_cnt, rare_sat
    );

    modport slave (
        input  valid_in, in_a, in_b, in_c, in_d,
        input  in_e, in_f, in_g, pol, cnt_clr,
        output out_node, out_valid, rare_cnt, rare_sat
    );
endinterface

// File: rtl/nt_node_pipe.sv
// nt_node_pipe: pipelined two-branch NAND trust node over WIDTH lanes.
// Ports: I1470_clk, I1477_rst (sync, active-high), bus (slave modport).
module nt_node_pipe #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 1,
    parameter int CNT_W = 8
) (
    input logic          I1470_clk,
    input logic          I1477_rst,
    nt_node_pipe_if.slave bus
);
    logic [WIDTH-1:0] a_q, b_q, c_q, d_q, e_q, f_q, g_q;
    logic [WIDTH-1:0] a_d, b_d, c_d, d_d, e_d, f_d, g_d;
    logic             pol_a_q, pol_a_d;
    logic             va_q, va_d;

    logic [WIDTH-1:0] p_term, n1, h_term, t_term;

    logic [DEPTH-1:0][WIDTH-1:0] t_dl_q, t_dl_d;
    logic [DEPTH-1:0]            pol_dl_q, pol_dl_d;
    logic [DEPTH-1:0]            v_dl_q, v_dl_d;

    logic [WIDTH-1:0] t_end;
    logic             pol_end;
    logic             v_end;

    logic [WIDTH-1:0] out_node_q, out_node_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] rare_cnt_q, rare_cnt_d;
    logic             rare_sat_q, rare_sat_d;

    always_comb begin
        a_d     = bus.in_a;
        b_d     = bus.in_b;
        c_d     = bus.in_c;
        d_d     = bus.in_d;
        e_d     = bus.in_e;
        f_d     = bus.in_f;
        g_d     = bus.in_g;
        pol_a_d = bus.pol;
        va_d    = bus.valid_in;
    end

    always_comb begin
        p_term = ~(f_q & a_q) & g_q & b_q;
        n1     = ~(a_q & d_q);
        h_term = (n1 | c_q) & e_q;
        t_term = p_term & h_term;
    end

    // Delay line balancing both branches; shifts every cycle, tag or not.
    always_comb begin
        t_dl_d      = t_dl_q;
        pol_dl_d    = pol_dl_q;
        v_dl_d      = v_dl_q;
        t_dl_d[0]   = t_term;
        pol_dl_d[0] = pol_a_q;
        v_dl_d[0]   = va_q;
        for (int i = 1; i < DEPTH; i++) begin
            t_dl_d[i]   = t_dl_q[i-1];
            pol_dl_d[i] = pol_dl_q[i-1];
            v_dl_d[i]   = v_dl_q[i-1];
        end
    end

    always_comb begin
        t_end   = t_dl_q[DEPTH-1];
        pol_end = pol_dl_q[DEPTH-1];
        v_end   = v_dl_q[DEPTH-1];
    end

    always_comb begin
        out_node_d  = out_node_q;
        out_valid_d = v_end;
        rare_cnt_d  = rare_cnt_q;
        if (v_end) begin
            out_node_d = pol_end ? t_end : ~t_end;
        end
        // Clear dominates; otherwise saturate at all-ones.
        if (bus.cnt_clr) begin
            rare_cnt_d = '0;
        end else if (v_end && (|t_end) && (rare_cnt_q != '1)) begin
            rare_cnt_d = rare_cnt_q + 1'b1;
        end
        rare_sat_d = (rare_cnt_d == '1);
    end

    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            e_q         <= '0;
            f_q         <= '0;
            g_q         <= '0;
            pol_a_q     <= 1'b0;
            va_q        <= 1'b0;
            t_dl_q      <= '0;
            pol_dl_q    <= '0;
            v_dl_q      <= '0;
            out_node_q  <= '1;
            out_valid_q <= 1'b0;
            rare_cnt_q  <= '0;
            rare_sat_q  <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            d_q         <= d_d;
            e_q         <= e_d;
            f_q         <= f_d;
            g_q         <= g_d;
            pol_a_q     <= pol_a_d;
            va_q        <= va_d;
            t_dl_q      <= t_dl_d;
            pol_dl_q    <= pol_dl_d;
            v_dl_q      <= v_dl_d;
            out_node_q  <= out_node_d;
            out_valid_q <= out_valid_d;
            rare_cnt_q  <= rare_cnt_d;
            rare_sat_q  <= rare_sat_d;
        end
    end

    assign bus.out_node  = out_node_q;
    assign bus.out_valid = out_valid_q;
    assign bus.rare_cnt  = rare_cnt_q;
    assign bus.rare_sat  = rare_sat_q;
endmodule

// File: tb/tb_nt_node_pipe.sv
// tb_nt_node_pipe: directed plus randomized checks of nt_node_pipe
// against a sample-level delay/counter reference model.
module tb_nt_node_pipe;
    localparam int W   = 4;
    localparam int D   = 2;
    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;
    localparam logic [W-1:0] F = '1;

    typedef struct {
        logic         v;
        logic         p;
        logic [W-1:0] t;
    } smp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    nt_node_pipe_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    nt_node_pipe #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
        .I1470_clk (clk),
        .I1477_rst (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    smp_t         q[$];
    logic [W-1:0] exp_out = '1;
    logic         exp_ov  = 1'b0;
    int           exp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Activation per lane, straight from the node equations.
    function automatic logic [W-1:0] act(
        input logic [W-1:0] a, b, c, d, e, f, g);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            bit pb = !(f[i] && a[i]) && g[i] && b[i];
            bit hb = (!(a[i] && d[i]) || c[i]) && e[i];
            r[i] = pb && hb;
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic p,
                         input logic [W-1:0] a, b, c, d, e, f, g);
        bus.valid_in = v;
        bus.pol      = p;
        bus.in_a = a; bus.in_b = b; bus.in_c = c;
        bus.in_d = d; bus.in_e = e; bus.in_f = f;
        bus.in_g = g;
    endtask

    task automatic idle();
        bus.valid_in = 1'b0;
    endtask

    // One clock: capture applied inputs, advance model, compare.
    task automatic cyc();
        smp_t s;
        smp_t h;
        bit   popped;
        bit   clr;
        bit   r;
        s.v = bus.valid_in;
        s.p = bus.pol;
        s.t = act(bus.in_a, bus.in_b, bus.in_c, bus.in_d,
                  bus.in_e, bus.in_f, bus.in_g);
        clr = bus.cnt_clr;
        r   = rst;
        @(posedge clk);
        #1;
        popped = 0;
        if (r) begin
            q.delete();
            exp_out = '1;
            exp_ov  = 1'b0;
            exp_cnt = 0;
        end else begin
            q.push_back(s);
            exp_ov = 1'b0;
            if (q.size() > D + 1) begin
                h = q.pop_front();
                popped = 1;
            end
            if (popped && h.v) begin
                exp_out = h.p ? h.t : ~h.t;
                exp_ov  = 1'b1;
            end
            if (clr) exp_cnt = 0;
            else if (popped && h.v && (h.t != 0) && exp_cnt < MAX)
                exp_cnt++;
        end
        chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        chk("out_node", 32'(bus.out_node), 32'(exp_out));
        chk("rare_cnt", 32'(bus.rare_cnt), 32'(exp_cnt));
        chk("rare_sat", 32'(bus.rare_sat), 32'(exp_cnt == MAX));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        bus.cnt_clr = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0, '0, '0, '0, '0);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(2);

        // Activating sample, NAND then AND polarity.
        drive(1, 0, F, F, 0, 0, F, 0, F); cyc();
        idle(); run(D + 3);
        drive(1, 1, F, F, 0, 0, F, 0, F); cyc();
        idle(); run(D + 3);

        // Guard low; then only lanes 0 and 2 guarded.
        drive(1, 0, F, F, 0, 0, 0, 0, F); cyc();
        idle(); run(D + 3);
        drive(1, 0, F, F, 0, 0, 4'b0101, 0, F); cyc();
        idle(); run(D + 3);

        // Bubbles between two differing samples.
        drive(1, 0, F, F, 0, 0, F, 0, F); cyc();
        idle(); run(2);
        drive(1, 1, 4'b0011, F, 0, 0, F, 0, F); cyc();
        idle(); run(D + 3);

        // Saturation, then clear against an activating sample.
        bus.cnt_clr = 1'b1; cyc(); bus.cnt_clr = 1'b0;
        drive(1, 0, F, F, 0, 0, F, 0, F);
        run(20);
        bus.cnt_clr = 1'b1; cyc();
        bus.cnt_clr = 1'b0;
        idle(); run(D + 3);

        // Reset while samples are in flight.
        drive(1, 0, F, F, 0, 0, F, 0, F); run(2);
        rst = 1'b1; cyc(); rst = 1'b0;
        idle(); run(D + 3);
        drive(1, 1, F, F, F, F, F, 0, F); cyc();
        idle(); run(D + 3);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 9) < 7), $urandom_range(0, 1),
                  W'($urandom), W'($urandom | $urandom),
                  W'($urandom), W'($urandom),
                  W'($urandom | $urandom), W'($urandom & $urandom),
                  W'($urandom | $urandom));
            bus.cnt_clr = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 99) == 0);
            cyc();
        end
        rst = 1'b0;
        bus.cnt_clr = 1'b0;
        idle(); run(D + 3);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/nt_node_pipe.md
# nt_node_pipe

Parametrised, pipelined trust-node subcircuit for the trojan-detection benchmark netlists. It evaluates the two-branch NAND node function, a registered product term combined with a registered enable/guard term, across WIDTH independent bit lanes. Branch latency is balanced and configurable through DEPTH, a valid tag travels with the data, and output polarity is selectable. A saturating rare-activation counter lets the detection harness measure how often the node's trigger condition fires.

## Interface
- WIDTH, 4, number of independent bit lanes (≥1)
- DEPTH, 1, balanced delay stages between stage A and the output register (≥1)
- CNT_W, 8, rare-activation counter width (≥2)

- I1470_clk  in  1  sole clock, rising edge
- I1477_rst  in  1  reset, synchronous, active-high
- valid_in  in  1  qualifies in_* and pol this cycle
- in_a, in_b, in_c, in_d, in_e, in_f, in_g  in  WIDTH each  node operands, bitwise per lane
- pol  in  1  0: NAND output (legacy); 1: AND output
- cnt_clr  in  1  synchronous clear of rare_cnt/rare_sat
- out_node  out  WIDTH  node output, registered
- out_valid  out  1  out_node updated this cycle with valid data
- rare_cnt  out  CNT_W  saturating count of activation cycles
- rare_sat  out  1  rare_cnt at all-ones

## Operation
- Stage A, every cycle: register all in_*, pol, and valid_in as vA. No stall or backpressure.
- Combinational, bitwise per lane, from the stage-A registers:
  - P = ~(f & a) & g & b
  - n1 = ~(a & d)
  - H = (n1 | c) & e
  - T = P & H is the activation term.
- T, pol, and vA shift through DEPTH registers unconditionally. Registers keep capturing when the tag is 0.
- Output register:
  - Loads only when the DEPTH-delayed tag vD = 1.
  - Loaded value: out_node = pol_D ? T_D : ~T_D.
  - When vD = 0, out_node holds its last value.
- out_valid = registered vD, a one-cycle pulse per valid sample.
- Counter:
  - On a cycle where vD = 1 and |T_D = 1 (any lane activated), rare_cnt increments by 1.
  - The count reaches all-ones and stays there. rare_sat = (rare_cnt == 2^CNT_W−1).
  - Counting is independent of pol.
- cnt_clr = 1 sets rare_cnt = 0 and rare_sat = 0 next cycle. Clear wins over a simultaneous increment.
- Reset values:
  - out_node = all-ones (legacy NAND idle level).
  - out_valid = 0, rare_cnt = 0, rare_sat = 0.
  - All valid tags = 0, pol pipeline = 0.
- Reset mid-operation: all in-flight tags are dropped, so no out_valid follows reset deassertion until new valid_in. Data registers may keep stale values but are never observed.
- Lanes are fully independent. There is no cross-lane logic except the OR feeding the counter.

## Timing
- Latency valid_in → out_valid/out_node: DEPTH+2 cycles (3 at default).
- Throughput: one sample per cycle. Back-to-back valid_in gives back-to-back out_valid.
- Counter update: same edge as the out_node load. rare_cnt is visible 1 cycle after the matching vD, i.e. coincident with out_valid.
- rare_sat asserts in the same cycle rare_cnt reaches all-ones.
- I1477_rst high at an edge overrides every other input that edge, including cnt_clr and valid_in.
- pol is sampled with its data. Changing pol mid-stream affects only samples captured after the change.

## Test plan
1. WIDTH=4, DEPTH=1: a=b=g=e=F, d=f=c=0, pol=0, one valid_in at cycle 0 → out_node=0 and out_valid=1 at cycle 3, rare_cnt=1. Same stimulus with pol=1 → out_node=F, rare_cnt=2.
2. As test 1 but e=0 (H=0) → out_node=F and out_valid=1 at cycle 3, rare_cnt stays 0. Lane isolation: e=4'b0101 → out_node=4'b1010, rare_cnt increments once.
3. Bubble hold: valid_in sequence 1,0,0,1 with differing data → out_valid 1,0,0,1 at cycles 3–6. out_node holds sample-0 value through cycles 4–5.
4. CNT_W=4, 20 consecutive activating samples → rare_cnt climbs to 15, rare_sat=1 from the 15th count onward and stays. Then cnt_clr asserted with an activating vD on the same edge → rare_cnt=0, rare_sat=0.
5. DEPTH=3: single valid sample → out_valid exactly at cycle 5. Continuous stream for 10 cycles → 10 out_valid pulses with no gaps.
6. Reset mid-flight: valid samples at cycles 0–2, I1477_rst high at cycle 2 → no out_valid afterward, out_node=F, rare_cnt=0. The first post-reset valid_in produces output DEPTH+2 cycles later.
